// File: rtl/sparc_exu_shdw_pkg.sv
// Shared types and width helpers for the EXU shadow-chain dump sequencer.
package sparc_exu_shdw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FREEZE,
    ST_DUMP,
    ST_FLUSH,
    ST_FIN
  } shdw_state_e;

  localparam int SHDW_CHAINS = 2;
  localparam int SHDW_WORD_W = 32;

  function automatic int chain_idx_w(input int chains);
    return (chains > 1) ? $clog2(chains) : 1;
  endfunction

  function automatic int nbits_w(input int word_w);
    return $clog2(word_w) + 1;
  endfunction

  localparam int SHDW_CH_W = chain_idx_w(SHDW_CHAINS);
  localparam int SHDW_NB_W = nbits_w(SHDW_WORD_W);

endpackage

// File: rtl/sparc_exu_shdw_pack.sv
// Serial-to-word packer: accumulator, output register with valid/ready, and
// the stall flag that keeps the accumulator from overflowing.
module sparc_exu_shdw_pack
  import sparc_exu_shdw_pkg::*;
#(
  parameter int WORD_W = SHDW_WORD_W,
  parameter int CH_W   = SHDW_CH_W,
  parameter int NB_W   = SHDW_NB_W
) (
  input  logic              sh_clk,
  input  logic              sh_rst,
  input  logic              bit_vld,
  input  logic              bit_dat,
  input  logic              pending,
  input  logic [CH_W-1:0]   chain_idx,
  input  logic              out_rdy,
  output logic [WORD_W-1:0] out_data,
  output logic [CH_W-1:0]   out_chain,
  output logic [NB_W-1:0]   out_nbits,
  output logic              out_last,
  output logic              out_vld,
  output logic              stall,
  output logic              last_load
);

  localparam logic [NB_W-1:0] FULL = NB_W'(WORD_W);

  logic [WORD_W-1:0] acc_q, acc_d, data_q, data_d;
  logic [NB_W-1:0]   cnt_q, cnt_d, nbits_q, nbits_d;
  logic [CH_W-1:0]   chain_q, chain_d;
  logic              last_q, last_d, vld_q, vld_d;
  logic              out_free, free_eff;

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    chain_d   = chain_q;
    nbits_d   = nbits_q;
    last_d    = last_q;
    vld_d     = vld_q && !out_rdy;
    out_free  = !vld_q || out_rdy;
    free_eff  = out_free;
    last_load = 1'b0;

    // A held full word goes out first, unless it is itself the chain's last word.
    if (cnt_q == FULL && out_free && !(pending && !bit_vld)) begin
      data_d   = acc_q;
      chain_d  = chain_idx;
      nbits_d  = FULL;
      last_d   = 1'b0;
      vld_d    = 1'b1;
      acc_d    = '0;
      cnt_d    = '0;
      free_eff = 1'b0;
    end

    if (bit_vld && cnt_d != FULL) begin
      acc_d = acc_d | (WORD_W'(bit_dat) << cnt_d);
      cnt_d = cnt_d + NB_W'(1);
    end

    if (free_eff && pending) begin
      data_d    = acc_d;
      chain_d   = chain_idx;
      nbits_d   = cnt_d;
      last_d    = 1'b1;
      vld_d     = 1'b1;
      acc_d     = '0;
      cnt_d     = '0;
      last_load = 1'b1;
    end else if (free_eff && cnt_d == FULL) begin
      data_d  = acc_d;
      chain_d = chain_idx;
      nbits_d = FULL;
      last_d  = 1'b0;
      vld_d   = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge sh_clk or posedge sh_rst) begin
    if (sh_rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      chain_q <= '0;
      nbits_q <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      chain_q <= chain_d;
      nbits_q <= nbits_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
    end
  end

  assign stall     = vld_q && !out_rdy && (cnt_q >= FULL - NB_W'(1));
  assign out_data  = data_q;
  assign out_chain = chain_q;
  assign out_nbits = nbits_q;
  assign out_last  = last_q;
  assign out_vld   = vld_q;

endmodule

// File: rtl/sparc_exu_shdw_dump_ctl.sv
// Shadow-chain dump sequencer: IDLE (capture) -> FREEZE -> DUMP/FLUSH per chain -> FIN.
// Owns the FSM, chain muxing and per-chain timeout; packing lives in sparc_exu_shdw_pack.
module sparc_exu_shdw_dump_ctl
  import sparc_exu_shdw_pkg::*;
#(
  parameter int CHAINS     = SHDW_CHAINS,
  parameter int WORD_W     = SHDW_WORD_W,
  parameter int FREEZE_CYC = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                              sh_clk,
  input  logic                              sh_rst,
  input  logic                              cap_arm,
  input  logic                              dump_req,
  input  logic [CHAINS-1:0]                 chain_dat,
  input  logic [CHAINS-1:0]                 chain_vld,
  input  logic [CHAINS-1:0]                 chain_done,
  output logic                              c_en,
  output logic [CHAINS-1:0]                 dump_en,
  output logic [WORD_W-1:0]                 out_data,
  output logic [chain_idx_w(CHAINS)-1:0]    out_chain,
  output logic [nbits_w(WORD_W)-1:0]        out_nbits,
  output logic                              out_last,
  output logic                              out_vld,
  input  logic                              out_rdy,
  output logic                              busy,
  output logic                              dump_done,
  output logic                              timeout_err
);

  localparam int CH_W  = chain_idx_w(CHAINS);
  localparam int NB_W  = nbits_w(WORD_W);
  localparam int FRZ_W = $clog2(FREEZE_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  shdw_state_e      state_q, state_d;
  logic [CH_W-1:0]  chain_q, chain_d;
  logic [FRZ_W-1:0] frz_q, frz_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             last_sent_q, last_sent_d;
  logic             c_en_q, c_en_d, busy_q, busy_d;
  logic             done_q, done_d, terr_q, terr_d;

  logic stall, last_load;
  logic vld_i, dat_i, done_i, en_i, to_hit, done_eff, bit_vld, pending;

  assign vld_i    = chain_vld[chain_q];
  assign dat_i    = chain_dat[chain_q];
  assign done_i   = chain_done[chain_q];
  assign en_i     = (state_q == ST_DUMP) && !stall;
  assign dump_en  = en_i ? (CHAINS'(1) << chain_q) : '0;
  assign to_hit   = en_i && !vld_i && !done_i && (to_q == TO_W'(TIMEOUT - 1));
  assign done_eff = (state_q == ST_DUMP) && (done_i || to_hit);
  assign bit_vld  = (state_q == ST_DUMP) && vld_i;
  // Last word is owed from the done cycle until the packer has taken it.
  assign pending  = done_eff || ((state_q == ST_FLUSH) && !last_sent_q);

  always_comb begin
    state_d     = state_q;
    chain_d     = chain_q;
    frz_d       = frz_q;
    to_d        = to_q;
    last_sent_d = last_sent_q;
    terr_d      = terr_q;

    case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          state_d = ST_FREEZE;
          frz_d   = FRZ_W'(FREEZE_CYC - 1);
          terr_d  = 1'b0;
        end
      end
      ST_FREEZE: begin
        if (frz_q == '0) begin
          state_d = ST_DUMP;
          chain_d = '0;
          to_d    = '0;
        end else begin
          frz_d = frz_q - FRZ_W'(1);
        end
      end
      ST_DUMP: begin
        if (vld_i || done_i) begin
          to_d = '0;
        end else if (en_i) begin
          to_d = to_q + TO_W'(1);
        end
        if (to_hit) terr_d = 1'b1;
        if (done_eff) begin
          state_d     = ST_FLUSH;
          last_sent_d = last_load;
        end
      end
      ST_FLUSH: begin
        if (last_load) last_sent_d = 1'b1;
        if (last_sent_q && out_rdy) begin
          last_sent_d = 1'b0;
          to_d        = '0;
          if (chain_q == CH_W'(CHAINS - 1)) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_DUMP;
            chain_d = chain_q + CH_W'(1);
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    c_en_d = (state_d == ST_IDLE) ? cap_arm : 1'b0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge sh_clk or posedge sh_rst) begin
    if (sh_rst) begin
      state_q     <= ST_IDLE;
      chain_q     <= '0;
      frz_q       <= '0;
      to_q        <= '0;
      last_sent_q <= 1'b0;
      c_en_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chain_q     <= chain_d;
      frz_q       <= frz_d;
      to_q        <= to_d;
      last_sent_q <= last_sent_d;
      c_en_q      <= c_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      terr_q      <= terr_d;
    end
  end

  assign c_en        = c_en_q;
  assign busy        = busy_q;
  assign dump_done   = done_q;
  assign timeout_err = terr_q;

  sparc_exu_shdw_pack #(
    .WORD_W (WORD_W),
    .CH_W   (CH_W),
    .NB_W   (NB_W)
  ) u_pack (
    .sh_clk    (sh_clk),
    .sh_rst    (sh_rst),
    .bit_vld   (bit_vld),
    .bit_dat   (dat_i),
    .pending   (pending),
    .chain_idx (chain_q),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_chain (out_chain),
    .out_nbits (out_nbits),
    .out_last  (out_last),
    .out_vld   (out_vld),
    .stall     (stall),
    .last_load (last_load)
  );

endmodule

// File: tb/tb_sparc_exu_shdw_dump_ctl.sv
// Directed bench for sparc_exu_shdw_dump_ctl: chain responders feed serial bits,
// expected words go to a scoreboard that is checked on each accepted output word.
module tb_sparc_exu_shdw_dump_ctl;

  localparam int CHAINS  = 2;
  localparam int WORD_W  = 32;
  localparam int TIMEOUT = 8;

  logic              sh_clk = 1'b0;
  logic              sh_rst = 1'b1;
  logic              cap_arm = 1'b0;
  logic              dump_req = 1'b0;
  logic              out_rdy = 1'b0;
  logic [CHAINS-1:0] chain_dat = '0;
  logic [CHAINS-1:0] chain_vld = '0;
  logic [CHAINS-1:0] chain_done = '0;
  logic              c_en, out_last, out_vld, busy, dump_done, timeout_err;
  logic [CHAINS-1:0] dump_en;
  logic [WORD_W-1:0] out_data;
  logic [0:0]        out_chain;
  logic [5:0]        out_nbits;

  typedef struct {
    logic [31:0] data;
    int          chain;
    int          nbits;
    bit          last;
  } word_t;

  word_t sb[$];
  word_t mon_wd;
  bit    chq[CHAINS][$];
  bit    active[CHAINS];
  bit    silent[CHAINS];
  bit    dwl[CHAINS];
  bit    en_prev[CHAINS];
  int    n_cmp = 0;
  int    n_mis = 0;

  sparc_exu_shdw_dump_ctl #(
    .CHAINS     (CHAINS),
    .WORD_W     (WORD_W),
    .FREEZE_CYC (2),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .sh_clk      (sh_clk),
    .sh_rst      (sh_rst),
    .cap_arm     (cap_arm),
    .dump_req    (dump_req),
    .chain_dat   (chain_dat),
    .chain_vld   (chain_vld),
    .chain_done  (chain_done),
    .c_en        (c_en),
    .dump_en     (dump_en),
    .out_data    (out_data),
    .out_chain   (out_chain),
    .out_nbits   (out_nbits),
    .out_last    (out_last),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .busy        (busy),
    .dump_done   (dump_done),
    .timeout_err (timeout_err)
  );

  always #5 sh_clk = ~sh_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue n random bits for chain c and push the words they must produce.
  task automatic push_chain(input int c, input int n, input bit with_last, input bit quiet);
    word_t       wd;
    logic [31:0] w = '0;
    int          k = 0;
    bit          b;
    active[c] = 1'b1;
    silent[c] = quiet;
    dwl[c]    = with_last;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      chq[c].push_back(b);
      w = w | (32'(b) << k);
      k++;
      if (k == 32) begin
        wd.data = w; wd.chain = c; wd.nbits = 32; wd.last = with_last && (i == n - 1);
        sb.push_back(wd);
        w = '0;
        k = 0;
      end
    end
    if (!(with_last && n > 0 && (n % 32) == 0)) begin
      wd.data = w; wd.chain = c; wd.nbits = k; wd.last = 1'b1;
      sb.push_back(wd);
    end
  endtask

  task automatic start_dump();
    dump_req = 1'b1;
    @(posedge sh_clk); #1;
    dump_req = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_c_en_low", 64'(c_en), 64'd0);
    @(posedge sh_clk); #1;
    chk("freeze_dump_en", 64'(dump_en), 64'd0);
    @(posedge sh_clk); #1;
    chk("first_dump_en", 64'(dump_en), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int i = 0;
    while (!dump_done && i < max_cyc) begin
      @(posedge sh_clk); #1;
      i++;
    end
    chk(tag, 64'(dump_done), 64'd1);
  endtask

  // Chain model: a bit (or done) follows the dump_en seen one cycle earlier,
  // so one bit can still arrive after dump_en falls.
  always @(negedge sh_clk) begin
    for (int c = 0; c < CHAINS; c++) begin
      chain_vld[c]  = 1'b0;
      chain_done[c] = 1'b0;
      chain_dat[c]  = 1'b0;
      if (!sh_rst && en_prev[c] && active[c] && !silent[c]) begin
        if (chq[c].size() > 0) begin
          chain_dat[c] = chq[c].pop_front();
          chain_vld[c] = 1'b1;
          if (chq[c].size() == 0 && dwl[c]) begin
            chain_done[c] = 1'b1;
            active[c]     = 1'b0;
          end
        end else begin
          chain_done[c] = 1'b1;
          active[c]     = 1'b0;
        end
      end
      en_prev[c] = !sh_rst && dump_en[c];
    end
  end

  always @(negedge sh_clk) begin
    if (!sh_rst && out_vld && out_rdy) begin
      chk("sb_has_word", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        mon_wd = sb.pop_front();
        chk("word_data", 64'(out_data), 64'(mon_wd.data));
        chk("word_chain", 64'(out_chain), 64'(mon_wd.chain));
        chk("word_nbits", 64'(out_nbits), 64'(mon_wd.nbits));
        chk("word_last", 64'(out_last), 64'(mon_wd.last));
      end
    end
  end

  initial begin
    for (int c = 0; c < CHAINS; c++) begin
      active[c] = 1'b0; silent[c] = 1'b0; dwl[c] = 1'b0; en_prev[c] = 1'b0;
    end
    repeat (2) @(posedge sh_clk);
    #1;
    chk("rst_c_en", 64'(c_en), 64'd0);
    chk("rst_dump_en", 64'(dump_en), 64'd0);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_nbits", 64'(out_nbits), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dump_done", 64'(dump_done), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    sh_rst = 1'b0;

    // idle capture follows cap_arm one cycle late
    @(posedge sh_clk); #1;
    cap_arm = 1'b1;
    @(negedge sh_clk);
    chk("c_en_latency", 64'(c_en), 64'd0);
    @(posedge sh_clk); #1;
    chk("c_en_rise", 64'(c_en), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_dump_en", 64'(dump_en), 64'd0);
    cap_arm = 1'b0;
    @(posedge sh_clk); #1;
    chk("c_en_fall", 64'(c_en), 64'd0);
    cap_arm = 1'b1;
    @(posedge sh_clk); #1;
    chk("c_en_rearm", 64'(c_en), 64'd1);

    // basic dump: 40 bits then 8 bits
    push_chain(0, 40, 1'b0, 1'b0);
    push_chain(1, 8, 1'b0, 1'b0);
    out_rdy = 1'b1;
    start_dump();
    wait_done("basic_done", 300);
    chk("basic_c_en_at_done", 64'(c_en), 64'd0);
    @(posedge sh_clk); #1;
    chk("basic_c_en_resume", 64'(c_en), 64'd1);
    chk("basic_busy_off", 64'(busy), 64'd0);
    chk("basic_sb_empty", 64'(sb.size()), 64'd0);

    // backpressure: 70 bits with consumer stalled
    out_rdy = 1'b0;
    push_chain(0, 70, 1'b0, 1'b0);
    push_chain(1, 8, 1'b0, 1'b0);
    start_dump();
    repeat (100) @(posedge sh_clk);
    #1;
    chk("bp_dump_en_low", 64'(dump_en), 64'd0);
    chk("bp_out_vld", 64'(out_vld), 64'd1);
    chk("bp_bits_left", 64'(chq[0].size()), 64'd6);
    chk("bp_hold_nbits", 64'(out_nbits), 64'd32);
    chk("bp_hold_data", 64'(out_data), 64'(sb[0].data));
    out_rdy = 1'b1;
    wait_done("bp_done", 300);
    @(posedge sh_clk); #1;
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // timeout on a silent chain 1, with a stray dump_req mid-dump
    push_chain(0, 5, 1'b0, 1'b0);
    push_chain(1, 0, 1'b0, 1'b1);
    start_dump();
    repeat (12) @(posedge sh_clk);
    #1;
    dump_req = 1'b1;
    @(posedge sh_clk); #1;
    dump_req = 1'b0;
    wait_done("to_done", 200);
    chk("to_err_set", 64'(timeout_err), 64'd1);
    repeat (3) @(posedge sh_clk);
    #1;
    chk("req_ignored_busy", 64'(busy), 64'd0);
    chk("to_sb_empty", 64'(sb.size()), 64'd0);
    chk("to_err_sticky", 64'(timeout_err), 64'd1);

    // done together with the 32nd bit, then 33 bits with separate done
    push_chain(0, 32, 1'b1, 1'b0);
    push_chain(1, 33, 1'b0, 1'b0);
    start_dump();
    chk("to_err_cleared", 64'(timeout_err), 64'd0);
    wait_done("edge_done", 300);
    @(posedge sh_clk); #1;
    chk("edge_sb_empty", 64'(sb.size()), 64'd0);

    // asynchronous reset while a word is waiting
    out_rdy = 1'b0;
    push_chain(0, 40, 1'b0, 1'b0);
    push_chain(1, 8, 1'b0, 1'b0);
    start_dump();
    for (int i = 0; i < 100 && !out_vld; i++) begin
      @(posedge sh_clk); #1;
    end
    chk("mid_rst_vld_before", 64'(out_vld), 64'd1);
    sh_rst = 1'b1;
    #1;
    chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_dump_en", 64'(dump_en), 64'd0);
    chk("mid_rst_c_en", 64'(c_en), 64'd0);
    sb.delete();
    for (int c = 0; c < CHAINS; c++) begin
      chq[c].delete();
      active[c] = 1'b0;
    end
    @(posedge sh_clk); #1;
    sh_rst = 1'b0;
    chk("post_rst_c_en", 64'(c_en), 64'd0);
    @(posedge sh_clk); #1;
    chk("post_rst_c_en_armed", 64'(c_en), 64'd1);
    out_rdy = 1'b1;
    push_chain(0, 10, 1'b0, 1'b0);
    push_chain(1, 3, 1'b0, 1'b0);
    start_dump();
    wait_done("restart_done", 200);
    @(posedge sh_clk); #1;
    chk("restart_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sparc_exu_shdw_dump_ctl.md
# sparc_exu_shdw_dump_ctl

Sequencer for the EXU shadow-capture chains. In normal running it holds capture enabled. On a dump request it freezes capture and dumps each chain in turn with one-hot `dump_en`, then packs the serial chain bits into words on a valid/ready output. It sits in the shadow clock domain, above the `c_en`/`dump_en`/`ch_out*` ports of the EXU datapath blocks, and returns to capture when all chains are drained.

## Interface
- `CHAINS`, 2: number of chains sequenced, dumped in index order 0..CHAINS-1.
- `WORD_W`, 32: packed output word width; must be ≥ 4.
- `FREEZE_CYC`, 2: cycles with `c_en` low before the first `dump_en`; must be ≥ 1.
- `TIMEOUT`, 255: idle cycles allowed per chain before abort; must be ≥ 1.
- `sh_clk`  in  1  sole clock, rising edge.
- `sh_rst`  in  1  reset; asynchronous, active-high.
- `cap_arm`  in  1  level; capture allowed while idle.
- `dump_req`  in  1  single-cycle pulse; start a dump.
- `chain_dat`  in  CHAINS  serial data from each chain's `ch_out`.
- `chain_vld`  in  CHAINS  bit valid from each chain's `ch_out_vld`.
- `chain_done`  in  CHAINS  end of chain from each chain's `ch_out_done`.
- `c_en`  out  1  capture enable to the chains.
- `dump_en`  out  CHAINS  one-hot dump enable.
- `out_data`  out  WORD_W  packed bits. The first received bit is in bit 0; unused upper bits are zero.
- `out_chain`  out  max(1,$clog2(CHAINS))  index of the chain this word belongs to.
- `out_nbits`  out  $clog2(WORD_W)+1  number of valid bits in the word, 0..WORD_W.
- `out_last`  out  1  final word of this chain.
- `out_vld`  out  1  word valid.
- `out_rdy`  in  1  consumer accepts the word.
- `busy`  out  1  high in every state except IDLE.
- `dump_done`  out  1  one-cycle pulse when the dump sequence finishes.
- `timeout_err`  out  1  sticky; cleared when a dump is accepted.

## Operation
- States:
  - IDLE: `c_en` = `cap_arm`. Move to FREEZE on `dump_req`.
  - FREEZE: `c_en` = 0; count FREEZE_CYC cycles, then go to DUMP with chain index i = 0.
  - DUMP(i): `dump_en[i]` asserted, subject to the stall rule below.
  - FLUSH(i): emit the final word of chain i. Then go to DUMP(i+1), or to FIN after chain CHAINS-1.
  - FIN: pulse `dump_done` and return to IDLE.
- `dump_req` is ignored outside IDLE. A dump proceeds whether or not `cap_arm` is high.
- In DUMP(i), only `chain_vld[i]`/`chain_dat[i]` are sampled; the other chains' inputs are ignored. Each valid bit is appended to the accumulator at position `acc_cnt`.
- When the accumulator holds WORD_W bits and the output register is empty, it moves to the output register with `out_nbits`=WORD_W and `out_last`=0.
- On `chain_done[i]`, the residual accumulator moves to the output as the last word: `out_last`=1, `out_nbits`=`acc_cnt`.
  - This happens even when `acc_cnt`=0, giving a zero-length end marker.
  - If a bit and `chain_done[i]` arrive in the same cycle, the bit is appended first.
- Stall rule: `dump_en[i]` = 0 whenever `out_vld && !out_rdy && acc_cnt ≥ WORD_W-1`. A chain may deliver one bit after `dump_en` falls; this rule absorbs it without loss.
- Timeout: the per-chain counter increments on every DUMP cycle where `dump_en[i]` is high and neither `chain_vld[i]` nor `chain_done[i]` is seen. It resets on any activity.
  - At TIMEOUT, set `timeout_err` and treat the cycle as `chain_done[i]`.
- `out_vld` holds until `out_rdy`; `out_data`/`out_chain`/`out_nbits`/`out_last` stay stable while `out_vld && !out_rdy`.

## Timing
- Reset values: state IDLE; `c_en`, `dump_en`, `out_*`, `busy`, `dump_done`, `timeout_err` all 0.
- All outputs are registered except `dump_en`, which is combinational from state and the stall condition.
- `c_en` follows `cap_arm` with 1-cycle latency in IDLE.
- `dump_req` at edge t → `busy`=1 and `c_en`=0 from t+1 → `dump_en[0]` high at t+1+FREEZE_CYC.
- The WORD_W-th bit, sampled at edge t, gives `out_vld` at t+1 if the output register is empty.
- `chain_done[i]` at edge t → last word `out_vld` at t+1 at the earliest. `dump_en[i+1]` rises only after that last word is accepted.
- FIN lasts 1 cycle; `c_en` resumes the cycle after `dump_done`.
- An asynchronous reset mid-dump drops everything, including an unaccepted word, and `c_en` stays 0 until `cap_arm` is sampled in IDLE.

## Structure
- Shared package `sparc_exu_shdw_pkg`: state enum (IDLE, FREEZE, DUMP, FLUSH, FIN) and the `$clog2`-derived width constants.
- Sub-module `sparc_exu_shdw_pack`: accumulator, output register, stall flag and valid/ready logic. The controller owns the FSM, chain muxing and the timeout counter.

## Test plan
- Idle capture: `cap_arm`=1, then 0 → `c_en` follows each with 1 cycle of latency; `dump_en`=0, `busy`=0.
- Basic dump: CHAINS=2, WORD_W=32, `out_rdy`=1; chain 0 sends 40 bits, chain 1 sends 8.
  - Expect words {chain 0, nbits 32, last 0}, {chain 0, 8, 1}, {chain 1, 8, 1}, then `dump_done`.
  - Bit order is LSB-first.
- Backpressure: `out_rdy`=0 while chain 0 streams 70 bits → `dump_en[0]` drops with `acc_cnt` ≥ 31. No bit is lost or duplicated; three words of 32/32/6 bits arrive once `out_rdy`=1.
- Timeout: chain 1 silent for TIMEOUT=8 cycles → `timeout_err`=1, last word {chain 1, nbits 0}, then `dump_done`. The next `dump_req` clears `timeout_err`.
- Edge events: `chain_done` with `chain_vld` on the 32nd bit → word {32, last 1}. `dump_req` during DUMP is ignored.
- Reset mid-dump: assert `sh_rst` while `out_vld`=1 → all outputs 0 immediately; a new dump after release restarts at chain 0.
